// File: rtl/uart_pkg.sv
// Shared UART definitions: frame length, FSM states, baud divisor table and parity helper.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int BAUD_W     = 19;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } uart_state_e;

  // Clock cycles per bit at a 100 MHz system clock.
  function automatic logic [BAUD_W-1:0] baud_count(input logic [3:0] sel);
    case (sel)
      4'd0:    return 19'd333333;
      4'd1:    return 19'd83333;
      4'd2:    return 19'd41667;
      4'd3:    return 19'd20833;
      4'd4:    return 19'd10417;
      4'd5:    return 19'd5208;
      4'd6:    return 19'd2604;
      4'd7:    return 19'd1736;
      4'd8:    return 19'd868;
      4'd9:    return 19'd434;
      4'd10:   return 19'd217;
      default: return 19'd109;
    endcase
  endfunction

  // Parity over the data bits actually on the wire; ohel = 1 selects odd.
  function automatic logic uart_parity(input logic [7:0] data,
                                       input logic       eight,
                                       input logic       ohel);
    return (^data[6:0]) ^ (eight & data[7]) ^ ohel;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Write-port and serial-line bundle between the processor side and the UART transmitter.
interface uart_tx_if;
  logic [3:0] baud_sel;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic       load;
  logic [7:0] data_in;
  logic       tx;
  logic       tx_rdy;
  logic       tx_done;

  modport master (
    output baud_sel, eight, pen, ohel, load, data_in,
    input  tx, tx_rdy, tx_done
  );

  modport slave (
    input  baud_sel, eight, pen, ohel, load, data_in,
    output tx, tx_rdy, tx_done
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-time generator: reloads K-1 and counts down, flagging the last cycle of each bit.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [BAUD_W-1:0] k,
  output logic              bit_tick
);

  logic [BAUD_W-1:0] cnt;

  // A zero count marks the first cycle of a bit, so one bit spans 0, K-1 .. 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= k - 19'd1;
    end else begin
      cnt <= cnt - 19'd1;
    end
  end

  assign bit_tick = run && (cnt == 19'd1);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: frames a byte as start, 7/8 data, optional parity and stop bits, sent LSB-first.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  uart_tx_if.slave   bus
);

  if (CLK_HZ != 100_000_000) begin : g_clk_check
    $error("uart_tx: baud table assumes a 100 MHz clock");
  end

  uart_state_e           state, state_nx;
  logic [FRAME_BITS-1:0] shift, shift_nx;
  logic [3:0]            bit_cnt, bit_nx;
  logic [3:0]            sel_q, sel_nx;
  logic                  tx_q, tx_nx;
  logic                  rdy_q, rdy_nx;
  logic                  done_q, done_nx;
  logic                  bit_tick;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d,
                                                        input logic       e,
                                                        input logic       p,
                                                        input logic       o);
    logic       par;
    logic [2:0] tail;
    par = uart_parity(d, e, o);
    case ({e, p})
      2'b00:   tail = 3'b111;
      2'b01:   tail = {2'b11, par};
      2'b10:   tail = {2'b11, d[7]};
      default: tail = {1'b1, par, d[7]};
    endcase
    return {tail, d[6:0], 1'b0};
  endfunction

  uart_bit_timer u_timer (
    .clk      (clk),
    .rst_n    (reset_n),
    .run      (state == SEND),
    .k        (baud_count(sel_q)),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_nx = state;
    shift_nx = shift;
    bit_nx   = bit_cnt;
    sel_nx   = sel_q;
    tx_nx    = tx_q;
    rdy_nx   = rdy_q;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        tx_nx  = 1'b1;
        rdy_nx = 1'b1;
        if (bus.load) begin
          shift_nx = build_frame(bus.data_in, bus.eight, bus.pen, bus.ohel);
          tx_nx    = 1'b0;
          bit_nx   = '0;
          sel_nx   = bus.baud_sel;
          rdy_nx   = 1'b0;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (bit_tick) begin
          if (bit_cnt == 4'(FRAME_BITS - 1)) begin
            state_nx = IDLE;
            bit_nx   = '0;
            tx_nx    = 1'b1;
            rdy_nx   = 1'b1;
            done_nx  = 1'b1;
          end else begin
            bit_nx   = bit_cnt + 4'd1;
            tx_nx    = shift[1];
            shift_nx = {1'b1, shift[FRAME_BITS-1:1]};
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Every output is a flop so the serial line never glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shift   <= '1;
      bit_cnt <= '0;
      sel_q   <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      shift   <= shift_nx;
      bit_cnt <= bit_nx;
      sel_q   <= sel_nx;
      tx_q    <= tx_nx;
      rdy_q   <= rdy_nx;
      done_q  <= done_nx;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_rdy  = rdy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of framed bytes plus reset, busy and back-to-back sequences.
module tb_uart_tx;

  typedef struct {
    logic [7:0]  data;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [3:0]  sel;
    int          k;
    int          poke;
    logic [10:0] frame;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;
  vec_t vecs[8];

  uart_tx_if bus ();

  uart_tx #(.CLK_HZ(100_000_000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input vec_t v);
    bus.data_in  = v.data;
    bus.eight    = v.eight;
    bus.pen      = v.pen;
    bus.ohel     = v.ohel;
    bus.baud_sel = v.sel;
    bus.load     = 1'b1;
    @(posedge clk);
    #1 bus.load = 1'b0;
  endtask

  // Samples every cycle of the frame; returns at the negedge of the tx_done cycle.
  task automatic capture(input vec_t v, input string tag);
    logic [10:0] got;
    int          unstable;
    int          busy_bad;
    int          n;
    got      = '1;
    unstable = 0;
    busy_bad = 0;
    for (int c = 1; c <= 11 * v.k; c++) begin
      @(negedge clk);
      if (v.poke != 0 && c == v.poke) begin
        bus.load     = 1'b1;
        bus.data_in  = 8'h00;
        bus.baud_sel = 4'd8;
        bus.eight    = 1'b0;
        bus.pen      = 1'b1;
        bus.ohel     = 1'b1;
      end else if (v.poke != 0 && c == v.poke + 1) begin
        bus.load = 1'b0;
      end
      n = (c - 1) / v.k;
      if ((c - 1) % v.k == 0) got[n] = bus.tx;
      else if (bus.tx !== got[n]) unstable++;
      if (bus.tx_done !== 1'b0 || bus.tx_rdy !== 1'b0) busy_bad++;
    end
    @(negedge clk);
    check({tag, " frame"}, 32'(got), 32'(v.frame));
    check({tag, " bit_stable"}, unstable, 0);
    check({tag, " busy_flags"}, busy_bad, 0);
    check({tag, " done_at_end"}, 32'(bus.tx_done), 1);
    check({tag, " tx_idle_at_end"}, 32'(bus.tx), 1);
    check({tag, " rdy_at_end"}, 32'(bus.tx_rdy), 1);
  endtask

  initial begin
    int bad;
    n_vec = 0;
    n_bad = 0;
    //          data   8     pen   ohel  sel    K    poke frame
    vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 4'd11, 109, 0,   11'h6AA};
    vecs[1] = '{8'hA7, 1'b1, 1'b1, 1'b0, 4'd11, 109, 0,   11'h74E};
    vecs[2] = '{8'hA7, 1'b1, 1'b1, 1'b1, 4'd11, 109, 0,   11'h54E};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 4'd11, 109, 0,   11'h7FE};
    vecs[4] = '{8'h80, 1'b0, 1'b0, 1'b0, 4'd12, 109, 0,   11'h700};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 4'd15, 109, 0,   11'h600};
    vecs[6] = '{8'h03, 1'b0, 1'b1, 1'b0, 4'd10, 217, 0,   11'h606};
    vecs[7] = '{8'h55, 1'b1, 1'b0, 1'b0, 4'd11, 109, 350, 11'h6AA};

    bus.load     = 1'b0;
    bus.data_in  = 8'h00;
    bus.baud_sel = 4'd11;
    bus.eight    = 1'b1;
    bus.pen      = 1'b0;
    bus.ohel     = 1'b0;
    reset_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", 32'(bus.tx), 1);
    check("reset tx_rdy", 32'(bus.tx_rdy), 1);
    check("reset tx_done", 32'(bus.tx_done), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i]);
      capture(vecs[i], $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d done_one_cycle", i), 32'(bus.tx_done), 0);
    end

    // Back-to-back: second load lands in the tx_done cycle of the first frame.
    do_load(vecs[0]);
    capture(vecs[0], "b2b_first");
    do_load(vecs[1]);
    capture(vecs[1], "b2b_second");
    @(negedge clk);

    // Reset mid-frame must idle the line at once and suppress tx_done.
    do_load(vecs[0]);
    repeat (500) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset tx", 32'(bus.tx), 1);
    check("midreset tx_rdy", 32'(bus.tx_rdy), 1);
    check("midreset tx_done", 32'(bus.tx_done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.tx_done !== 1'b0 || bus.tx_rdy !== 1'b1) bad++;
    end
    check("post_reset quiet", bad, 0);

    do_load(vecs[2]);
    capture(vecs[2], "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
